// File: rtl/aes_io_pkg.sv
// aes_io_pkg: keypad key map, scanner FSM state encoding and column priority helper.
package aes_io_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;

    // KEYMAP[row][col] gives the hex code of the key at that crossing
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    // lowest-index low column wins when several keys share the driven row
    function automatic logic [1:0] low_col(input logic [3:0] c);
        return !c[0] ? 2'd0 : !c[1] ? 2'd1 : !c[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad matrix lines plus the key strobe bus toward the memory/LCD stage.
//   col       keypad column lines, active-low
//   row       one-cold row drive
//   data_out1 hex code of the last accepted key
//   key_valid one-clk strobe when data_out1 updates
//   key_held  high while the accepted key stays pressed
//   slave  = scanner side, master = keypad/consumer side
interface keypad_scan_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] data_out1;
    logic       key_valid;
    logic       key_held;
    modport slave (input col, output row, data_out1, key_valid, key_held);
    modport master (output col, input row, data_out1, key_valid, key_held);
endinterface

// File: rtl/kp_sync2.sv
// kp_sync2: 2-flop synchronizer for the 4 asynchronous column lines, idles at 4'hF.
//   clk, reset  clock and synchronous active-high reset
//   d           asynchronous input
//   q           synchronized output
module kp_sync2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);
    logic [3:0] meta;
    always_ff @(posedge clk) begin
        if (reset) {q, meta} <= 8'hFF;
        else       {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce, one strobe per accepted key.
//   clk, reset  clock and synchronous active-high reset
//   kp          keypad_scan_if.slave: col in, row/data_out1/key_valid/key_held out
//   Define KEYPAD_REPEAT_EN to re-strobe a held key every REPEAT_SCANS ticks.
module keypad_scan
    import aes_io_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 20,
    parameter int REPEAT_SCANS   = 500
) (
    input  logic          clk,
    input  logic          reset,
    keypad_scan_if.slave  kp
);
    localparam int         TW = $clog2(SCAN_DIV);
    localparam logic [7:0] DB = 8'(DEBOUNCE_SCANS);

    logic [3:0]    col_s;
    logic [TW-1:0] tcnt;
    logic          tick;
    kp_state_t     state, nxt_state;
    logic [1:0]    ridx, nxt_ridx;
    logic [3:0]    cap, nxt_cap;
    logic [7:0]    cnt, nxt_cnt, cnt_inc;
    logic          accept, rep;

    kp_sync2 u_sync (.clk(clk), .reset(reset), .d(kp.col), .q(col_s));

    assign tick    = tcnt == TW'(SCAN_DIV - 1);
    assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (reset || tick) tcnt <= '0;
        else               tcnt <= tcnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SCAN;
            ridx         <= 2'd0;
            cap          <= 4'hF;
            cnt          <= 8'd0;
            kp.data_out1 <= 4'h0;
            kp.key_valid <= 1'b0;
        end else begin
            state        <= nxt_state;
            ridx         <= nxt_ridx;
            cap          <= nxt_cap;
            cnt          <= nxt_cnt;
            kp.key_valid <= accept | rep;
            if (accept) kp.data_out1 <= KEYMAP[ridx][low_col(col_s)];
        end
    end

    // acceptance always happens with col_s equal to the captured pattern,
    // so the key code can be looked up from col_s directly
    always_comb begin
        nxt_state = state;
        nxt_ridx  = ridx;
        nxt_cap   = cap;
        nxt_cnt   = cnt;
        accept    = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (col_s == 4'hF) nxt_ridx = ridx + 2'd1;
                    else begin
                        nxt_cap   = col_s;
                        accept    = DB <= 8'd1;
                        nxt_cnt   = accept ? 8'd0 : 8'd1;
                        nxt_state = accept ? HELD : DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    accept    = col_s == cap && cnt_inc >= DB;
                    nxt_cnt   = (col_s == cap && !accept) ? cnt_inc : 8'd0;
                    nxt_state = col_s != cap ? SCAN : accept ? HELD : DEBOUNCE;
                end
                HELD: begin
                    if (col_s == 4'hF) begin
                        nxt_cnt   = DB <= 8'd1 ? 8'd0 : 8'd1;
                        nxt_state = DB <= 8'd1 ? SCAN : RELEASE;
                    end
                end
                RELEASE: begin
                    nxt_cnt   = col_s != 4'hF || cnt_inc >= DB ? 8'd0 : cnt_inc;
                    nxt_state = col_s != 4'hF ? HELD : cnt_inc >= DB ? SCAN : RELEASE;
                end
            endcase
        end
    end

    always_comb begin
        kp.row      = ~(4'b0001 << ridx);
        kp.key_held = state == HELD || state == RELEASE;
    end

`ifdef KEYPAD_REPEAT_EN
    // the 8-bit repeat counter caps the repeat period at 255 ticks
    localparam logic [7:0] RP = REPEAT_SCANS > 255 ? 8'd255 : 8'(REPEAT_SCANS);
    logic [7:0] rcnt, rcnt_inc;
    logic       rtick;
    assign rtick    = tick && state == HELD && col_s != 4'hF;
    assign rcnt_inc = (rcnt == 8'hFF) ? rcnt : rcnt + 8'd1;
    assign rep      = rtick && rcnt_inc >= RP;
    // counter is zero whenever outside HELD, so it starts clear on every entry
    always_ff @(posedge clk) begin
        if (reset || state != HELD || rep) rcnt <= 8'd0;
        else if (rtick)                    rcnt <= rcnt_inc;
    end
`else
    logic unused_rep;
    assign unused_rep = REPEAT_SCANS != 0;
    assign rep        = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed self-checking bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=5).
module tb_keypad_scan;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_down = 1'b0;
    logic [3:0] key_row = 4'b1110;
    logic [3:0] key_pat = 4'hF;
    int         cyc = 0;
    int         pulses = 0;
    int         doubles = 0;
    int         tests = 0;
    int         fails = 0;
    int         p0 = 0;
    logic       last_valid = 1'b0;

    always #5 clk = ~clk;

    keypad_scan_if kif ();

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .REPEAT_SCANS(5)) dut (
        .clk(clk),
        .reset(reset),
        .kp(kif)
    );

    // keypad model: the pressed key pulls its column low only while its row is driven
    assign kif.col = (key_down && kif.row == key_row) ? key_pat : 4'hF;

    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (kif.key_valid) pulses <= pulses + 1;
        if (kif.key_valid && last_valid) doubles <= doubles + 1;
        last_valid <= kif.key_valid;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance past n scan ticks; a tick is processed on every 4th edge after reset
    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            while (cyc % 4 != 0) @(negedge clk);
        end
        #1;
    endtask

    task automatic wait_held(input int bound);
        for (int i = 0; i < bound && !kif.key_held; i++) ticks(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_row", 8'(kif.row), 8'hE);
        check("rst_data", 8'(kif.data_out1), 8'h0);
        check("rst_valid", 8'(kif.key_valid), 8'h0);
        check("rst_held", 8'(kif.key_held), 8'h0);
        reset = 1'b0;

        key_row = 4'b1011; key_pat = 4'b1101; key_down = 1'b1;
        wait_held(20);
        check("acc_held", 8'(kif.key_held), 8'h1);
        check("acc_data", 8'(kif.data_out1), 8'h8);
        check("acc_pulses", 8'(pulses), 8'd1);
        check("acc_row_frozen", 8'(kif.row), 8'hB);

        key_down = 1'b0;
        ticks(2);
        check("rel_held_2", 8'(kif.key_held), 8'h1);
        ticks(1);
        check("rel_held_3", 8'(kif.key_held), 8'h0);
        check("rel_pulses", 8'(pulses), 8'd1);

        key_row = 4'b1110; key_pat = 4'b1001; key_down = 1'b1;
        wait_held(20);
        check("lowcol_held", 8'(kif.key_held), 8'h1);
        check("lowcol_data", 8'(kif.data_out1), 8'h2);
        check("lowcol_pulses", 8'(pulses), 8'd2);

        key_down = 1'b0;
        ticks(1);
        key_down = 1'b1;
        ticks(1);
        check("glitch_held", 8'(kif.key_held), 8'h1);
        key_down = 1'b0;
        ticks(2);
        check("glitch_restart", 8'(kif.key_held), 8'h1);
        ticks(1);
        check("glitch_fall", 8'(kif.key_held), 8'h0);
        check("glitch_pulses", 8'(pulses), 8'd2);

        key_pat = 4'b0111; key_down = 1'b1;
        ticks(1);
        key_down = 1'b0;
        ticks(1);
        check("bounce_row", 8'(kif.row), 8'hE);
        check("bounce_pulses_a", 8'(pulses), 8'd2);
        key_down = 1'b1;
        ticks(2);
        check("bounce_pulses_b", 8'(pulses), 8'd2);
        check("bounce_held_b", 8'(kif.key_held), 8'h0);
        ticks(1);
        check("bounce_pulses_c", 8'(pulses), 8'd3);
        check("bounce_held_c", 8'(kif.key_held), 8'h1);
        check("bounce_data", 8'(kif.data_out1), 8'hA);
        key_down = 1'b0;
        ticks(3);
        check("bounce_rel", 8'(kif.key_held), 8'h0);

        key_pat = 4'b1110; key_down = 1'b1;
        ticks(2);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_valid", 8'(kif.key_valid), 8'h0);
        check("mid_rst_row", 8'(kif.row), 8'hE);
        check("mid_rst_data", 8'(kif.data_out1), 8'h0);
        check("mid_rst_held", 8'(kif.key_held), 8'h0);
        key_down = 1'b0;
        reset = 1'b0;
        ticks(1);
        check("restart_row", 8'(kif.row), 8'hD);
        check("restart_pulses", 8'(pulses), 8'd3);

        key_row = 4'b1101; key_pat = 4'b1110; key_down = 1'b1;
        p0 = pulses;
        ticks(20);
        check("rep_data", 8'(kif.data_out1), 8'h4);
        check("rep_held", 8'(kif.key_held), 8'h1);
`ifdef KEYPAD_REPEAT_EN
        check("rep_pulses", 8'(pulses - p0), 8'd4);
`else
        check("rep_pulses", 8'(pulses - p0), 8'd1);
`endif
        key_down = 1'b0;
        ticks(3);
        check("rep_rel", 8'(kif.key_held), 8'h0);
        check("no_back_to_back", 8'(doubles), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
